// File: rtl/quic_enc_head.sv
// quic_enc_head: QUIC encoder header writer.
// Latches image type/width/height on an accepted start, then emits the header
// words magic, version, type, width, height to the packer via valid/ready.
// Optional feature macro: QUIC_HEAD_CHECK_EN appends a sixth word (CHECK),
// the XOR of the five preceding header words.
//
// state    | code | meaning
// ---------+------+-------------------------------------------------
// S_IDLE   |  0   | waiting for start; rejects zero width/height
// S_QUIC   |  1   | presenting magic word
// S_VERSION|  2   | presenting version word
// S_TYPE   |  3   | presenting {24'h0, type}
// S_WIDTH  |  4   | presenting {16'h0, width}
// S_HEIGHT |  5   | presenting {16'h0, height}
// S_CHECK  |  6   | presenting XOR of previous words (check build only)
// S_DONE   |  7   | one-cycle done pulse, then back to idle
module quic_enc_head #(
  parameter logic [31:0] QUIC_MAGIC   = 32'h4349_5551,
  parameter logic [31:0] QUIC_VERSION = 32'h0000_0001
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        enc_set,
  input  logic        start,
  input  logic [7:0]  type_4,
  input  logic [15:0] width,
  input  logic [15:0] height,
  output logic [31:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic [2:0]  header_state,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_QUIC    = 3'd1,
    S_VERSION = 3'd2,
    S_TYPE    = 3'd3,
    S_WIDTH   = 3'd4,
    S_HEIGHT  = 3'd5,
    S_CHECK   = 3'd6,
    S_DONE    = 3'd7
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [7:0]  r_type;
  logic [15:0] r_width;
  logic [15:0] r_height;
  logic        r_err;
  logic        w_dims_ok;
  logic        w_accept;
  logic        w_reject;
  logic        w_hs;
  logic [31:0] w_check;

  assign w_dims_ok = (width != 16'd0) && (height != 16'd0);
  assign w_accept  = (r_state == S_IDLE) && start && w_dims_ok && !enc_set;
  assign w_reject  = (r_state == S_IDLE) && start && !w_dims_ok && !enc_set;
  assign w_hs      = word_valid && word_ready;
  assign w_check   = QUIC_MAGIC ^ QUIC_VERSION ^ {24'h0, r_type}
                   ^ {16'h0, r_width} ^ {16'h0, r_height};

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state logic; enc_set wins over handshakes and start.
  always_comb begin
    w_state_nxt = r_state;
    if (enc_set) begin
      w_state_nxt = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:    if (start && w_dims_ok) w_state_nxt = S_QUIC;
        S_QUIC:    if (w_hs) w_state_nxt = S_VERSION;
        S_VERSION: if (w_hs) w_state_nxt = S_TYPE;
        S_TYPE:    if (w_hs) w_state_nxt = S_WIDTH;
        S_WIDTH:   if (w_hs) w_state_nxt = S_HEIGHT;
`ifdef QUIC_HEAD_CHECK_EN
        S_HEIGHT:  if (w_hs) w_state_nxt = S_CHECK;
        S_CHECK:   if (w_hs) w_state_nxt = S_DONE;
`else
        S_HEIGHT:  if (w_hs) w_state_nxt = S_DONE;
        S_CHECK:   w_state_nxt = S_IDLE;
`endif
        S_DONE:    w_state_nxt = S_IDLE;
        default:   w_state_nxt = S_IDLE;
      endcase
    end
  end

  // Header field latches, captured only on an accepted start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_type   <= 8'h0;
      r_width  <= 16'h0;
      r_height <= 16'h0;
    end else if (enc_set) begin
      r_type   <= 8'h0;
      r_width  <= 16'h0;
      r_height <= 16'h0;
    end else if (w_accept) begin
      r_type   <= type_4;
      r_width  <= width;
      r_height <= height;
    end
  end

  // Error pulse one cycle after a rejected start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_err <= 1'b0;
    else          r_err <= w_reject;
  end

  // Word mux and status outputs, derived from state and latched fields.
  always_comb begin
    word_out   = 32'h0;
    word_valid = 1'b0;
    case (r_state)
      S_QUIC:    begin word_out = QUIC_MAGIC;         word_valid = 1'b1; end
      S_VERSION: begin word_out = QUIC_VERSION;       word_valid = 1'b1; end
      S_TYPE:    begin word_out = {24'h0, r_type};    word_valid = 1'b1; end
      S_WIDTH:   begin word_out = {16'h0, r_width};   word_valid = 1'b1; end
      S_HEIGHT:  begin word_out = {16'h0, r_height};  word_valid = 1'b1; end
`ifdef QUIC_HEAD_CHECK_EN
      S_CHECK:   begin word_out = w_check;            word_valid = 1'b1; end
`endif
      default:   begin word_out = 32'h0;              word_valid = 1'b0; end
    endcase
  end

  assign header_state = r_state;
  assign busy         = (r_state != S_IDLE);
  assign done         = (r_state == S_DONE);
  assign err          = r_err;

`ifndef QUIC_HEAD_CHECK_EN
  logic w_unused_check;
  assign w_unused_check = ^w_check;
`endif

endmodule

// File: tb/tb_quic_enc_head.sv
// Testbench for quic_enc_head: scoreboard queue filled by stimulus, drained by
// a negedge monitor; reference header built from the field rules directly.
module tb_quic_enc_head;

  localparam logic [31:0] MAGIC   = 32'h4349_5551;
  localparam logic [31:0] VERSION = 32'h0000_0001;
`ifdef QUIC_HEAD_CHECK_EN
  localparam int HDR_WORDS = 6;
`else
  localparam int HDR_WORDS = 5;
`endif

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        enc_set = 1'b0;
  logic        start = 1'b0;
  logic [7:0]  type_4 = 8'h0;
  logic [15:0] width = 16'h0;
  logic [15:0] height = 16'h0;
  logic [31:0] word_out;
  logic        word_valid;
  logic        word_ready = 1'b1;
  logic [2:0]  header_state;
  logic        busy;
  logic        done;
  logic        err;

  quic_enc_head dut (
    .clk(clk), .reset_n(reset_n), .enc_set(enc_set), .start(start),
    .type_4(type_4), .width(width), .height(height),
    .word_out(word_out), .word_valid(word_valid), .word_ready(word_ready),
    .header_state(header_state), .busy(busy), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;   // 0 word, 1 done, 2 err
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   start_cyc = 0;
  int   done_cyc  = -1;
  int   ready_mode = 0;   // 0 always high, 1 toggle, 2 random
  logic        hold_pend = 1'b0;
  logic [31:0] hold_word = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference header: fields laid out as the encoder format defines them.
  task automatic push_header(input logic [7:0] t, input logic [15:0] w,
                             input logic [15:0] h);
    logic [31:0] words[6];
    logic [31:0] x;
    exp_t e;
    if (w == 0 || h == 0) begin
      e.kind = 2; e.data = 32'h0; exp_q.push_back(e);
      return;
    end
    words[0] = MAGIC;
    words[1] = VERSION;
    words[2] = 32'(t);
    words[3] = 32'(w);
    words[4] = 32'(h);
    x = 32'h0;
    for (int i = 0; i < 5; i++) x = x ^ words[i];
    words[5] = x;
    for (int i = 0; i < HDR_WORDS; i++) begin
      e.kind = 0; e.data = words[i]; exp_q.push_back(e);
    end
    e.kind = 1; e.data = 32'h0; exp_q.push_back(e);
  endtask

  // Ready driver.
  initial begin
    forever begin
      @(posedge clk); #1;
      case (ready_mode)
        0:       word_ready = 1'b1;
        1:       word_ready = ~word_ready;
        default: word_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: compares every DUT output event against the scoreboard.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n) begin
        if (hold_pend && word_valid && !enc_set)
          check(word_out == hold_word, "stable_while_stalled", word_out, hold_word);
        if (!word_valid)
          check(word_out == 32'h0, "word_out_zero_when_invalid", word_out, 32'h0);
`ifndef QUIC_HEAD_CHECK_EN
        if (header_state == 3'd6)
          check(1'b0, "check_state_reached", 32'(header_state), 32'd5);
`endif
        if (done) begin
          done_cyc = cyc;
          if (exp_q.size() > 0 && exp_q[0].kind == 1) begin
            check(1'b1, "done", 32'd1, 32'd1);
            void'(exp_q.pop_front());
          end else check(1'b0, "unexpected_done", 32'd1, 32'd0);
        end
        if (err) begin
          if (exp_q.size() > 0 && exp_q[0].kind == 2) begin
            check(1'b1, "err", 32'd1, 32'd1);
            void'(exp_q.pop_front());
          end else check(1'b0, "unexpected_err", 32'd1, 32'd0);
        end
        if (word_valid && word_ready && !enc_set) begin
          if (exp_q.size() > 0 && exp_q[0].kind == 0) begin
            check(word_out == exp_q[0].data, "header_word", word_out, exp_q[0].data);
            void'(exp_q.pop_front());
          end else check(1'b0, "unexpected_word", word_out, 32'h0);
        end
        hold_pend = word_valid && !word_ready && !enc_set;
        hold_word = word_out;
      end else begin
        hold_pend = 1'b0;
      end
    end
  end

  task automatic issue(input logic [7:0] t, input logic [15:0] w,
                       input logic [15:0] h);
    @(posedge clk); #1;
    type_4 = t; width = w; height = h; start = 1'b1;
    start_cyc = cyc;
    push_header(t, w, h);
    @(posedge clk); #1;
    start = 1'b0;
    type_4 = 8'($urandom); width = 16'($urandom); height = 16'($urandom);
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || busy) && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= budget) begin
      check(1'b0, "timeout_waiting_idle", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit, got %0d expected 0 pending", exp_q.size());
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0]  rt;
    logic [15:0] rw, rh;

    // Reset and idle.
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    check(header_state == 3'd0, "reset_state", 32'(header_state), 32'd0);
    check({word_valid, busy, done, err} == 4'b0, "reset_flags",
          32'({word_valid, busy, done, err}), 32'd0);
    check(word_out == 32'h0, "reset_word", word_out, 32'h0);

    // Directed header, ready always high: latency check.
    ready_mode = 0;
    issue(8'h04, 16'd640, 16'd480);
    wait_idle(100);
    check(done_cyc - start_cyc == HDR_WORDS + 1, "done_latency",
          32'(done_cyc - start_cyc), 32'(HDR_WORDS + 1));

    // Same header with ready toggling.
    ready_mode = 1;
    issue(8'h04, 16'd640, 16'd480);
    wait_idle(100);

    // Rejected start: zero width.
    ready_mode = 0;
    issue(8'h04, 16'd0, 16'd16);
    for (int i = 0; i < 3; i++) begin
      check(busy == 1'b0, "busy_after_reject", 32'(busy), 32'd0);
      check(word_valid == 1'b0, "valid_after_reject", 32'(word_valid), 32'd0);
      @(posedge clk); #1;
    end
    wait_idle(20);

    // enc_set on the WIDTH handshake.
    issue(8'h11, 16'd100, 16'd200);
    begin
      int n;
      n = 0;
      while (header_state != 3'd4 && n < 20) begin @(posedge clk); #1; n++; end
      check(header_state == 3'd4, "reach_width", 32'(header_state), 32'd4);
    end
    enc_set = 1'b1;
    @(posedge clk); #1;
    enc_set = 1'b0;
    check(header_state == 3'd0, "abort_to_idle", 32'(header_state), 32'd0);
    check(busy == 1'b0, "abort_busy", 32'(busy), 32'd0);
    exp_q.delete();
    repeat (4) @(posedge clk);
    #1;
    issue(8'h11, 16'd100, 16'd200);
    wait_idle(100);

    // Reset mid-header.
    issue(8'h22, 16'd7, 16'd9);
    @(posedge clk); #2;
    reset_n = 1'b0;
    #1;
    check({word_valid, busy, done} == 3'b0, "async_reset_outputs",
          32'({word_valid, busy, done}), 32'd0);
    check(header_state == 3'd0, "async_reset_state", 32'(header_state), 32'd0);
    exp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Randomized headers.
    for (int k = 0; k < 40; k++) begin
      ready_mode = int'($urandom_range(0, 2));
      rt = 8'($urandom);
      rw = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      rh = ($urandom_range(0, 7) == 0) ? 16'd0 : 16'($urandom);
      issue(rt, rw, rh);
      if (busy && $urandom_range(0, 1) == 1) begin
        // Start while busy must be ignored.
        start = 1'b1; width = 16'd0; height = 16'd0;
        @(posedge clk); #1;
        start = 1'b0;
      end
      wait_idle(300);
    end

    check(exp_q.size() == 0, "scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
